apb_master_ctrl: RTL and testbench

- APB master transfer-control state machine: sequences the IDLE -> SETUP -> ACCESS phases of the APB protocol.
- Drives the peripheral select (pselx) and enable (penable) strobes from a local transfer request and the slave's pready.
- Sits between the bus-request logic and the APB slave interface; address/data paths live elsewhere.

---
 rtl/apb_master_ctrl.sv | 74 +++++++
 tb/tb_apb_master_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//   APB master transfer-control state machine. Sequences the IDLE -> SETUP ->
//   ACCESS phases of an APB transfer and drives the pselx/penable strobes.
//   Address and data paths are handled elsewhere.
//
// Ports
//   clk      in   system clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset, overrides every other input
//   pready   in   slave ready, completes the ACCESS phase when high
//   transfer in   request for a new or back-to-back APB transfer
//   pselx    out  peripheral select, high in SETUP and ACCESS
//   penable  out  enable strobe, high only in ACCESS
module apb_master_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic pready,
   input  logic transfer,
   output logic pselx,
   output logic penable
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StSetup  = 2'b01,
      StAccess = 2'b10
   } state_e;

   state_e state_q;

   // Single state register; next-state decode lives in the same block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (transfer) state_q <= StSetup;
            end
            StSetup: begin
               state_q <= StAccess;
            end
            StAccess: begin
               // Back-to-back transfers skip IDLE so pselx never drops.
               if (pready) state_q <= transfer ? StSetup : StIdle;
            end
            default: begin
               // Unused encoding 2'b11 recovers to IDLE.
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Outputs depend on the state register only, so no input reaches them
   // combinationally.
   always_comb begin
      pselx   = 1'b0;
      penable = 1'b0;
      case (state_q)
         StSetup: begin
            pselx = 1'b1;
         end
         StAccess: begin
            pselx   = 1'b1;
            penable = 1'b1;
         end
         default: begin
            pselx   = 1'b0;
            penable = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl
//   Table-driven check of apb_master_ctrl: a list of {rst, transfer, pready}
//   inputs with the pselx/penable values expected after the clock edge that
//   samples them, followed by a short random soak against a small model.
module tb_apb_master_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic pready;
   logic transfer;
   logic pselx;
   logic penable;

   int checks   = 0;
   int failures = 0;

   apb_master_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .pready   (pready),
      .transfer (transfer),
      .pselx    (pselx),
      .penable  (penable)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst;
      logic transfer;
      logic pready;
      logic psel;
      logic pen;
   } vec_t;

   localparam int NumVec = 25;
   vec_t vecs [NumVec];

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got pselx/penable=%b want=%b", name, act, exp);
      end
   endtask

   initial begin
      logic [1:0] prev1;
      logic [1:0] prev2;
      int         ms;
      logic       r_t;
      logic       r_p;

      // {rst, transfer, pready, exp pselx, exp penable} after the sampling edge
      // Reset held two edges with transfer/pready high.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      // Release with transfer=1: SETUP, then zero-wait ACCESS, then IDLE.
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      // IDLE ignores pready.
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      // Transfer with three wait states: penable high for four cycles.
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      // Back-to-back with transfer and pready held high.
      vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      // SETUP ignores its inputs, then ACCESS waits; reset mid-access.
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      // Reset in SETUP beats transfer and pready.
      vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst      = vecs[0].rst;
      transfer = vecs[0].transfer;
      pready   = vecs[0].pready;

      for (int i = 0; i < NumVec; i++) begin
         rst      = vecs[i].rst;
         transfer = vecs[i].transfer;
         pready   = vecs[i].pready;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), {pselx, penable}, {vecs[i].psel, vecs[i].pen});
         // Wiggle inputs mid-cycle: outputs must not follow them.
         transfer = ~transfer;
         pready   = ~pready;
         #2;
         chk($sformatf("vec%0d_hold", i), {pselx, penable}, {vecs[i].psel, vecs[i].pen});
      end

      // Random soak from IDLE, checked against a small model and invariants.
      ms    = 0;
      prev1 = 2'b00;
      prev2 = 2'b00;
      rst   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         r_t      = 1'($urandom_range(0, 1));
         r_p      = 1'($urandom_range(0, 1));
         transfer = r_t;
         pready   = r_p;
         @(posedge clk);
         #1;
         case (ms)
            0:       ms = r_t ? 1 : 0;
            1:       ms = 2;
            default: ms = r_p ? (r_t ? 1 : 0) : 2;
         endcase
         chk($sformatf("soak%0d_model", c), {pselx, penable},
             {ms != 0 ? 1'b1 : 1'b0, ms == 2 ? 1'b1 : 1'b0});
         chk($sformatf("soak%0d_pen_implies_psel", c), {pselx, penable},
             {pselx | penable, penable});
         if (penable && !prev1[0]) begin
            // A rising penable must follow exactly one SETUP cycle.
            chk($sformatf("soak%0d_setup_before_pen", c),
                {prev1 == 2'b10 ? 1'b1 : 1'b0, prev2 == 2'b10 ? 1'b1 : 1'b0}, 2'b10);
         end
         prev2 = prev1;
         prev1 = {pselx, penable};
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
